// File: rtl/tick_gen_pkg.sv
// Shared definitions for the enable-tick prescaler: FSM state encodings and
// default widths.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tick_state_e;

  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

endpackage : tick_gen_pkg

// File: rtl/tick_div_counter.sv
// Period counter for the prescaler: counts 0..terminal while enabled and
// strobes wrap combinationally during the last cycle of each period.
module tick_div_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic         wrap
);

  logic [W-1:0] cnt_reg;
  logic         at_term;

  assign at_term = (cnt_reg == terminal);
  assign wrap    = enable && at_term;

  // The clearing edge is itself the first cycle of the period, so counting
  // resumes at 1; for a one-cycle period the only legal value is 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= (terminal == '0) ? '0 : W'(1);
    end else if (enable) begin
      cnt_reg <= at_term ? '0 : cnt_reg + W'(1);
    end
  end

endmodule : tick_div_counter

// File: rtl/enable_tick_gen.sv
// Programmable prescaler producing one-cycle enable ticks, free-running or in
// fixed-length bursts, with start/retrigger/stop control.
module enable_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] divisor,
  input  logic [CNT_W-1:0] burst_len,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  tick_state_e      state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [CNT_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic             tick_reg, tick_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             start_acc;
  logic             cnt_enable;
  logic             wrap;
  logic             last_tick;
  logic [DIV_W-1:0] new_div;
  logic [DIV_W-1:0] terminal;

  assign new_div    = (divisor == '0) ? DIV_W'(1) : divisor;
  assign start_acc  = start && !stop;
  assign cnt_enable = (state_reg == ST_RUN) && !stop && !start;
  assign terminal   = (start_acc ? new_div : div_reg) - DIV_W'(1);
  // The tick currently on the output is the final one of a bounded burst.
  assign last_tick  = tick_reg && (len_reg != '0) && (tick_cnt_reg == len_reg);

  tick_div_counter #(.W(DIV_W)) u_div_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (start_acc),
    .enable   (cnt_enable),
    .terminal (terminal),
    .wrap     (wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      div_reg      <= DIV_W'(1);
      len_reg      <= '0;
      tick_cnt_reg <= '0;
      tick_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      len_reg      <= len_next;
      tick_cnt_reg <= tick_cnt_next;
      tick_reg     <= tick_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    len_next      = len_reg;
    tick_cnt_next = tick_cnt_reg;
    tick_next     = 1'b0;

    if (stop) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_RUN;
      div_next   = new_div;
      len_next   = burst_len;
      // With a one-cycle period the first tick lands right after the start edge.
      if (new_div == DIV_W'(1)) begin
        tick_next     = 1'b1;
        tick_cnt_next = CNT_W'(1);
      end else begin
        tick_cnt_next = '0;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (last_tick) begin
            state_next = ST_DONE;
          end else if (wrap) begin
            tick_next     = 1'b1;
            tick_cnt_next = tick_cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end

    busy_next = (state_next == ST_RUN);
    done_next = (state_next == ST_DONE);
  end

  assign tick     = tick_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign tick_cnt = tick_cnt_reg;

endmodule : enable_tick_gen

// File: tb/tb_enable_tick_gen.sv
// Directed self-checking bench for enable_tick_gen; inputs change and outputs
// are sampled on the falling edge, k counts cycles after the sampling edge.
module tb_enable_tick_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [15:0] divisor;
  logic [7:0]  burst_len;
  logic        tick;
  logic        busy;
  logic        done;
  logic [7:0]  tick_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  enable_tick_gen #(.DIV_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .divisor   (divisor),
    .burst_len (burst_len),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leave start high across one sampling edge, then drop it.
  task automatic pulse_start(input logic [15:0] d, input logic [7:0] n);
    divisor   = d;
    burst_len = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    int ticks;
    int dones;
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    divisor   = '0;
    burst_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_tick", tick, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", tick_cnt, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Reset mid-run: divisor 5, free-run, ticks at k=5,10.
    $display("step: reset mid-run");
    pulse_start(16'd5, 8'd0);
    repeat (6) @(negedge clk);
    chk("mid_cnt_before", tick_cnt, 1);
    chk("mid_busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_tick", tick, 0);
    chk("async_busy", busy, 0);
    chk("async_cnt", tick_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_idle_busy", busy, 0);
    chk("post_reset_idle_tick", tick, 0);

    // Burst divisor 4 x 3: ticks k=4,8,12, done k=13, busy k=1..12.
    $display("step: burst d=4 n=3");
    pulse_start(16'd4, 8'd3);
    divisor   = 16'd2;
    burst_len = 8'd9;
    for (int k = 1; k <= 15; k++) begin
      chk($sformatf("b43_tick_k%0d", k), tick, (k == 4 || k == 8 || k == 12) ? 1 : 0);
      chk($sformatf("b43_done_k%0d", k), done, (k == 13) ? 1 : 0);
      chk($sformatf("b43_busy_k%0d", k), busy, (k <= 12) ? 1 : 0);
      @(negedge clk);
    end
    chk("b43_cnt", tick_cnt, 3);

    // Divisor 0 and 1, burst 5: tick k=1..5, done k=6.
    for (int d = 0; d <= 1; d++) begin
      $display("step: burst d=%0d n=5", d);
      pulse_start(16'(d), 8'd5);
      for (int k = 1; k <= 8; k++) begin
        chk($sformatf("d%0d_tick_k%0d", d, k), tick, (k <= 5) ? 1 : 0);
        chk($sformatf("d%0d_done_k%0d", d, k), done, (k == 6) ? 1 : 0);
        chk($sformatf("d%0d_busy_k%0d", d, k), busy, (k <= 5) ? 1 : 0);
        @(negedge clk);
      end
      chk($sformatf("d%0d_cnt", d), tick_cnt, 5);
    end

    // Largest burst length at divisor 1: 255 ticks then done.
    $display("step: burst d=1 n=255");
    pulse_start(16'd1, 8'd255);
    ticks = 0;
    dones = 0;
    for (int k = 1; k <= 258; k++) begin
      if (tick) ticks++;
      if (done) begin
        dones++;
        chk("b255_done_cycle", k, 256);
      end
      @(negedge clk);
    end
    chk("b255_ticks", ticks, 255);
    chk("b255_dones", dones, 1);
    chk("b255_cnt", tick_cnt, 255);

    // Free-run divisor 3 for 260 ticks: counter wraps through 0 to 4.
    $display("step: free-run d=3 260 ticks");
    pulse_start(16'd3, 8'd0);
    ticks = 0;
    dones = 0;
    for (int k = 1; k <= 780; k++) begin
      if (tick) ticks++;
      if (done) dones++;
      if (k == 768) chk("fr_wrap_zero", tick_cnt, 0);
      if (k < 780) @(negedge clk);
    end
    chk("fr_ticks", ticks, 260);
    chk("fr_cnt", tick_cnt, 4);
    chk("fr_no_done", dones, 0);
    chk("fr_busy", busy, 1);

    // Stop and start together: stop wins, counter holds.
    $display("step: stop+start priority");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    pulse_start(16'd6, 8'd0);
    repeat (7) @(negedge clk);
    chk("ss_cnt_before", tick_cnt, 1);
    stop      = 1'b1;
    start     = 1'b1;
    divisor   = 16'd2;
    @(negedge clk);
    stop      = 1'b0;
    start     = 1'b0;
    ticks = 0;
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      if (tick) ticks++;
      if (done) dones++;
      chk($sformatf("ss_busy_k%0d", k), busy, 0);
      @(negedge clk);
    end
    chk("ss_no_ticks", ticks, 0);
    chk("ss_no_done", dones, 0);
    chk("ss_cnt_held", tick_cnt, 1);
    pulse_start(16'd2, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("d2_tick_k%0d", k), tick, (k % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end

    // Retrigger: divisor 8 run, retrigger with 3 after 5 cycles.
    $display("step: retrigger");
    pulse_start(16'd8, 8'd0);
    repeat (4) @(negedge clk);
    pulse_start(16'd3, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) chk("rt_cnt_restart", tick_cnt, 0);
      if (k == 7) divisor = 16'd7;
      chk($sformatf("rt_tick_k%0d", k), tick, (k % 3 == 0) ? 1 : 0);
      @(negedge clk);
    end
    chk("rt_cnt", tick_cnt, 4);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_enable_tick_gen
